fifo_burst_reader: RTL and testbench
====================================

# fifo_burst_reader

Downstream consumer of the showahead `fifo` core. It monitors FIFO fill level, reads fixed-length bursts, and presents them on a valid/ready stream with start/end-of-burst markers. Partial data left in the FIFO is flushed as a short burst after an idle timeout. It connects directly to the `fifo` core ports (SHOWAHEAD=1, REGISTER_OUTPUT=0), so `q` is valid whenever `empty` is low and `rdreq` pops in the same cycle.

## Interface
- DWIDTH, 32, data word width
- AWIDTH, 10, FIFO address width; `usedw` is AWIDTH+1 bits
- BURST_LEN, 16, words per full burst; 1 ≤ BURST_LEN ≤ 2**AWIDTH
- TIMEOUT, 256, idle cycles before a short burst is flushed; 0 disables short bursts
- clk_i  in  1  clock
- arst_n_i  in  1  reset, asynchronous, active-low
- enable_i  in  1  permits starting new bursts; a burst in progress always completes
- fifo_q_i  in  DWIDTH  showahead FIFO head word
- fifo_empty_i  in  1  FIFO empty
- fifo_usedw_i  in  AWIDTH+1  FIFO occupancy
- fifo_rdreq_o  out  1  pop request to FIFO
- m_data_o  out  DWIDTH  stream data
- m_valid_o  out  1  stream data valid
- m_ready_i  in  1  downstream accepts the word
- m_sop_o  out  1  first word of burst, qualified by m_valid_o
- m_eop_o  out  1  last word of burst, qualified by m_valid_o
- busy_o  out  1  FSM in BURST, or stream buffer holds data

## Operation
- FSM states are IDLE and BURST.
- IDLE to BURST with length BURST_LEN when enable_i=1 and usedw ≥ BURST_LEN.
- IDLE to BURST with length latched from usedw when enable_i=1, TIMEOUT≠0, !empty, and the timeout counter = TIMEOUT−1. If both conditions hold, the full burst wins.
- Timeout counter: width $clog2(TIMEOUT+1). Increments in IDLE while !empty and usedw < BURST_LEN. Clears on empty, on burst start, and while enable_i=0.
- words_left: width $clog2(BURST_LEN+1). Loaded with the burst length on entry to BURST and decrements on each pop. On the pop that makes it 0, the FSM returns to IDLE.
- fifo_rdreq_o = (state==BURST) && words_left≠0 && !fifo_empty_i && !skid_valid. This is combinational from registered state and FIFO flags only, with no path from m_ready_i.
- Output stage is a 2-entry skid buffer (output register plus skid register). A popped word goes to the output register if it is empty or being consumed this cycle; otherwise it goes to the skid register. On a handshake with skid_valid=1, the skid word moves to the output register.
- SOP/EOP travel with each word: SOP on the first pop of the burst, EOP on the pop with words_left==1.
- Empty FIFO during BURST (external misuse only): rdreq stays low and the burst stalls without error.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, both buffer entries invalid. Reset takes effect immediately (async) and releases synchronously with clk_i.
- Latency: burst condition true at cycle N, then BURST at N+1, first rdreq at N+1, first m_valid_o at N+2.
- Throughput: one word per cycle while m_ready_i=1. Back-to-back bursts are separated by at least 1 IDLE cycle.
- m_data_o, m_sop_o and m_eop_o are held stable while m_valid_o && !m_ready_i.
- Reset mid-burst aborts the frame and no EOP is emitted. Words not yet popped remain in the FIFO and form a new burst with SOP after reset.
- enable_i falling during BURST has no effect until the return to IDLE.

## Structure
- `fifo_burst_pkg` holds the state enum typedef and localparam width helpers for the words_left and timeout counters.
- Sub-module `stream_skid_buf` carries payload {sop, eop, data}, sized from DWIDTH+2, with valid/ready on both sides and an exposed skid_valid.
- FSM and counters live in `fifo_burst_reader`.

## Test plan
- Full burst: 16 words 0..15 preloaded, m_ready_i=1. rdreq is high for 16 consecutive cycles, data 0..15 in order, SOP on 0, EOP on 15, busy_o drops 2 cycles after the last pop.
- Timeout flush: 3 words written, then idle. A burst of 3 starts exactly 256 cycles after the first non-empty IDLE cycle, with EOP on word 3 and usedw ending at 0.
- Backpressure: m_ready_i toggles 1/0 every cycle during a 16-word burst. No loss or duplication, order is preserved, rdreq is never asserted while skid_valid=1, and outputs are stable while stalled.
- Mixed: 40 words preloaded yields bursts of 16 and 16, then 8 after the timeout, each with exactly one SOP and one EOP.
- Enable gating: 20 words with enable_i=0 gives no rdreq for 100 cycles. After enable_i rises, the 16-word burst starts within 1 cycle, and the remaining 4 words flush after the timeout.
- Reset mid-burst: arst_n_i asserted after word 7 is accepted. All outputs are 0 in the same cycle. After release, the remaining 9 words arrive as a new burst, with SOP on word 8 and EOP on word 16 via the timeout.

Source files
------------

// File: rtl/fifo_burst_pkg.sv
// Shared types and width helpers for the FIFO burst reader.
// The counter widths are derived from the burst length and the idle timeout.
package fifo_burst_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // words_left must hold the full burst length itself
  function automatic int words_left_width(input int burst_len);
    return $clog2(burst_len + 1);
  endfunction

  // A disabled timeout still gets a 1-bit counter so the vector is legal
  function automatic int timeout_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/fifo_burst_reader_skid.sv
// Two-entry output stage: an output register backed by one skid register.
// The upstream side must not present a word while skid_valid_o is high.
module stream_skid_buf #(
  parameter int W = 34
) (
  input  logic         clk_i,
  input  logic         arst_n_i,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic         skid_valid_o
);

  logic [W-1:0] out_data_r;
  logic         out_valid_r;
  logic [W-1:0] skid_data_r;
  logic         skid_valid_r;

  // Output/skid register update on push, pop, and skid drain
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      out_data_r   <= '0;
      out_valid_r  <= 1'b0;
      skid_data_r  <= '0;
      skid_valid_r <= 1'b0;
    end else begin
      if (out_valid_r && out_ready_i) begin
        if (skid_valid_r) begin
          out_data_r  <= skid_data_r;
          out_valid_r <= 1'b1;
          if (in_valid_i) begin
            skid_data_r  <= in_data_i;
            skid_valid_r <= 1'b1;
          end else begin
            skid_valid_r <= 1'b0;
          end
        end else if (in_valid_i) begin
          out_data_r  <= in_data_i;
          out_valid_r <= 1'b1;
        end else begin
          out_valid_r <= 1'b0;
        end
      end else if (!out_valid_r) begin
        if (in_valid_i) begin
          out_data_r  <= in_data_i;
          out_valid_r <= 1'b1;
        end
      end else if (in_valid_i) begin
        // Output is stalled: park the new word behind it
        skid_data_r  <= in_data_i;
        skid_valid_r <= 1'b1;
      end
    end
  end

  assign in_ready_o   = !skid_valid_r;
  assign out_data_o   = out_data_r;
  assign out_valid_o  = out_valid_r;
  assign skid_valid_o = skid_valid_r;

endmodule

// File: rtl/fifo_burst_reader.sv
// Reads fixed-length bursts from a showahead FIFO and streams them out with SOP/EOP.
// Residual words are flushed as a short burst once the FIFO has sat idle for TIMEOUT cycles.
module fifo_burst_reader
  import fifo_burst_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 10,
  parameter int BURST_LEN = 16,
  parameter int TIMEOUT   = 256
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              enable_i,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic              fifo_empty_i,
  input  logic [AWIDTH:0]   fifo_usedw_i,
  output logic              fifo_rdreq_o,
  output logic [DWIDTH-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              m_sop_o,
  output logic              m_eop_o,
  output logic              busy_o
);

  localparam int WLW = words_left_width(BURST_LEN);
  localparam int TOW = timeout_width(TIMEOUT);
  localparam int PW  = DWIDTH + 2;
  localparam bit TMO_EN = (TIMEOUT > 0);
  localparam logic [AWIDTH:0] BURST_LEN_U = (AWIDTH + 1)'(BURST_LEN);
  localparam logic [TOW-1:0]  TMO_LAST    = TMO_EN ? TOW'(TIMEOUT - 1) : '0;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [WLW-1:0] words_left_r;
  logic [WLW-1:0] words_left_nxt_s;
  logic [TOW-1:0] tmo_cnt_r;
  logic [TOW-1:0] tmo_cnt_nxt_s;
  logic           sop_pend_r;
  logic           sop_pend_nxt_s;
  logic           full_go_s;
  logic           tmo_go_s;
  logic           rdreq_s;
  logic           skid_ready_s;
  logic           skid_valid_s;
  logic           out_valid_s;
  logic [PW-1:0]  payload_in_s;
  logic [PW-1:0]  payload_out_s;

  assign full_go_s = enable_i && (fifo_usedw_i >= BURST_LEN_U);
  // A zero occupancy would load an unfinishable burst, so it never counts as a flush
  assign tmo_go_s  = TMO_EN && enable_i && !fifo_empty_i &&
                     (fifo_usedw_i != '0) && (tmo_cnt_r == TMO_LAST);

  assign rdreq_s = (state_r == ST_BURST) && (words_left_r != '0) &&
                   !fifo_empty_i && skid_ready_s;

  // Next-state, burst length and timeout counter decisions
  always_comb begin
    state_nxt_s      = state_r;
    words_left_nxt_s = words_left_r;
    tmo_cnt_nxt_s    = tmo_cnt_r;
    sop_pend_nxt_s   = sop_pend_r;
    case (state_r)
      ST_IDLE: begin
        if (full_go_s) begin
          state_nxt_s      = ST_BURST;
          words_left_nxt_s = WLW'(BURST_LEN);
          tmo_cnt_nxt_s    = '0;
          sop_pend_nxt_s   = 1'b1;
        end else if (tmo_go_s) begin
          state_nxt_s      = ST_BURST;
          words_left_nxt_s = WLW'(fifo_usedw_i);
          tmo_cnt_nxt_s    = '0;
          sop_pend_nxt_s   = 1'b1;
        end else if (!enable_i || fifo_empty_i) begin
          tmo_cnt_nxt_s = '0;
        end else if (tmo_cnt_r != TMO_LAST) begin
          tmo_cnt_nxt_s = tmo_cnt_r + TOW'(1);
        end else begin
          tmo_cnt_nxt_s = tmo_cnt_r;
        end
      end
      ST_BURST: begin
        tmo_cnt_nxt_s = '0;
        if (rdreq_s) begin
          words_left_nxt_s = words_left_r - WLW'(1);
          sop_pend_nxt_s   = 1'b0;
          if (words_left_r == WLW'(1)) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_BURST;
          end
        end else begin
          state_nxt_s = ST_BURST;
        end
      end
      default: begin
        state_nxt_s      = ST_IDLE;
        words_left_nxt_s = '0;
        tmo_cnt_nxt_s    = '0;
        sop_pend_nxt_s   = 1'b0;
      end
    endcase
  end

  // FSM and counter registers
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_r      <= ST_IDLE;
      words_left_r <= '0;
      tmo_cnt_r    <= '0;
      sop_pend_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      words_left_r <= words_left_nxt_s;
      tmo_cnt_r    <= tmo_cnt_nxt_s;
      sop_pend_r   <= sop_pend_nxt_s;
    end
  end

  assign payload_in_s = {sop_pend_r, (words_left_r == WLW'(1)), fifo_q_i};

  stream_skid_buf #(
    .W (PW)
  ) u_skid (
    .clk_i        (clk_i),
    .arst_n_i     (arst_n_i),
    .in_data_i    (payload_in_s),
    .in_valid_i   (rdreq_s),
    .in_ready_o   (skid_ready_s),
    .out_data_o   (payload_out_s),
    .out_valid_o  (out_valid_s),
    .out_ready_i  (m_ready_i),
    .skid_valid_o (skid_valid_s)
  );

  assign fifo_rdreq_o = rdreq_s;
  assign m_valid_o    = out_valid_s;
  assign m_sop_o      = payload_out_s[DWIDTH+1];
  assign m_eop_o      = payload_out_s[DWIDTH];
  assign m_data_o     = payload_out_s[DWIDTH-1:0];
  assign busy_o       = (state_r == ST_BURST) || out_valid_s || skid_valid_s;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed + randomized bench: a queue-based showahead FIFO feeds the reader and the
// received stream is compared with bursts carved from the written words.
module tb_fifo_burst_reader;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int BL = 16;
  localparam int TO = 256;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
  } word_t;

  logic          clk = 1'b0;
  logic          arst_n = 1'b1;
  logic          enable = 1'b0;
  logic [DW-1:0] fifo_q = '0;
  logic          fifo_empty = 1'b1;
  logic [AW:0]   fifo_usedw = '0;
  logic          rdreq;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          m_sop;
  logic          m_eop;
  logic          busy;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int rmode = 0;
  int underflow_err = 0;
  int stall_err = 0;
  int skid_rd_err = 0;
  logic  stalled_prev = 1'b0;
  logic  busy_prev = 1'b0;
  word_t held_w = '0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] pend[$];
  logic [DW-1:0] expw[$];
  word_t rx[$];
  int    rx_cyc[$];
  int    rd_cyc[$];
  int    busy_fall[$];

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .DWIDTH (DW), .AWIDTH (AW), .BURST_LEN (BL), .TIMEOUT (TO)
  ) dut (
    .clk_i        (clk),
    .arst_n_i     (arst_n),
    .enable_i     (enable),
    .fifo_q_i     (fifo_q),
    .fifo_empty_i (fifo_empty),
    .fifo_usedw_i (fifo_usedw),
    .fifo_rdreq_o (rdreq),
    .m_data_o     (m_data),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready),
    .m_sop_o      (m_sop),
    .m_eop_o      (m_eop),
    .busy_o       (busy)
  );

  // Showahead FIFO model: pop on rdreq, push on wr_en, flags follow the queue
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rdreq) begin
      if (fq.size() == 0) underflow_err <= underflow_err + 1;
      else void'(fq.pop_front());
    end
    if (wr_en) fq.push_back(wr_data);
    fifo_empty <= (fq.size() == 0);
    fifo_usedw <= (AW + 1)'(fq.size());
    fifo_q     <= (fq.size() != 0) ? fq[0] : '0;
  end

  // Stream sink and per-cycle protocol observation
  always @(negedge clk) begin
    if (arst_n) begin
      if (rdreq) rd_cyc.push_back(cyc);
      if (rdreq && dut.skid_valid_s) skid_rd_err <= skid_rd_err + 1;
      if (m_valid && m_ready) begin
        rx.push_back({m_sop, m_eop, m_data});
        rx_cyc.push_back(cyc);
      end
      if (stalled_prev && (!m_valid || (word_t'({m_sop, m_eop, m_data}) !== held_w)))
        stall_err <= stall_err + 1;
      stalled_prev <= m_valid && !m_ready;
      held_w       <= {m_sop, m_eop, m_data};
      if (busy_prev && !busy) busy_fall.push_back(cyc);
      busy_prev <= busy;
    end else begin
      stalled_prev <= 1'b0;
      busy_prev    <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    case (rmode)
      1:       m_ready = ~m_ready;
      2:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b1;
    endcase
    if (pend.size() > 0) begin
      wr_en   = 1'b1;
      wr_data = pend.pop_front();
    end else begin
      wr_en = 1'b0;
    end
  endtask

  task automatic load(input int n, input bit seq, input int start);
    logic [DW-1:0] d;
    expw.delete();
    for (int i = 0; i < n; i++) begin
      d = seq ? DW'(start + i) : DW'($urandom);
      pend.push_back(d);
      expw.push_back(d);
    end
  endtask

  task automatic preload();
    while (pend.size() > 0) step();
    step();
    step();
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int t = 0;
    while (!(pend.size() == 0 && fifo_empty && !busy) && t < budget) begin
      step();
      t++;
    end
    check({tag, "_idle"}, 64'(t < budget), 64'd1);
    repeat (3) step();
  endtask

  // Expected stream: words split into BL-sized bursts, the tail forming a short burst
  task automatic check_stream(input string tag, input int base);
    int n;
    int pos;
    int clen;
    word_t e;
    n = expw.size();
    check({tag, "_count"}, 64'(rx.size() - base), 64'(n));
    for (int k = 0; k < n; k++) begin
      pos  = k % BL;
      clen = (n - (k - pos) < BL) ? (n - (k - pos)) : BL;
      e    = {(pos == 0), (pos == clen - 1), expw[k]};
      if (base + k < rx.size()) check({tag, "_word"}, 64'(rx[base + k]), 64'(e));
    end
  endtask

  initial begin
    int rxb, rdb, bfb, c_en, c_w, n, t;
    word_t e;

    #2 arst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdreq", 64'(rdreq), 64'd0);
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_data",  64'(m_data), 64'd0);
    check("rst_sop",   64'(m_sop), 64'd0);
    check("rst_eop",   64'(m_eop), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    @(negedge clk);
    arst_n = 1'b1;

    // Full burst of 0..15
    rmode = 0;
    load(16, 1'b1, 0);
    preload();
    rxb = rx.size(); rdb = rd_cyc.size(); bfb = busy_fall.size();
    enable = 1'b1;
    c_en = cyc;
    run_until_idle("full", 500);
    check("full_rd_count", 64'(rd_cyc.size() - rdb), 64'd16);
    if (rd_cyc.size() - rdb >= 16) begin
      check("full_rd_contig", 64'(rd_cyc[rdb + 15] - rd_cyc[rdb]), 64'd15);
      check("full_rd_start", 64'(rd_cyc[rdb] - c_en), 64'd1);
      if (rx.size() > rxb) check("full_valid_lat", 64'(rx_cyc[rxb] - rd_cyc[rdb]), 64'd1);
      if (busy_fall.size() > bfb)
        check("full_busy_drop", 64'(busy_fall[bfb] - rd_cyc[rdb + 15]), 64'd2);
    end
    check_stream("full", rxb);

    // Timeout flush of 3 words
    load(3, 1'b0, 0);
    rxb = rx.size(); rdb = rd_cyc.size();
    step();
    c_w = cyc;
    run_until_idle("tmo", 1000);
    check("tmo_rd_count", 64'(rd_cyc.size() - rdb), 64'd3);
    if (rd_cyc.size() > rdb) check("tmo_start", 64'(rd_cyc[rdb] - (c_w + 1)), 64'(TO));
    check("tmo_usedw", 64'(fifo_usedw), 64'd0);
    check_stream("tmo", rxb);

    // Backpressure: ready toggles every cycle
    enable = 1'b0;
    load(16, 1'b0, 0);
    preload();
    rxb = rx.size(); rdb = rd_cyc.size();
    rmode = 1;
    enable = 1'b1;
    run_until_idle("bp", 500);
    check("bp_rd_count", 64'(rd_cyc.size() - rdb), 64'd16);
    check("bp_skid_rd", 64'(skid_rd_err), 64'd0);
    check("bp_stable", 64'(stall_err), 64'd0);
    check_stream("bp", rxb);

    // Mixed: 40 words give 16 + 16 + 8, random backpressure
    enable = 1'b0;
    rmode = 0;
    load(40, 1'b0, 0);
    preload();
    rxb = rx.size();
    rmode = 2;
    enable = 1'b1;
    run_until_idle("mix", 2000);
    check_stream("mix", rxb);

    // Enable gating
    enable = 1'b0;
    rmode = 0;
    load(20, 1'b0, 0);
    rxb = rx.size(); rdb = rd_cyc.size();
    repeat (100) step();
    check("gate_no_rd", 64'(rd_cyc.size() - rdb), 64'd0);
    enable = 1'b1;
    c_en = cyc;
    run_until_idle("gate", 1000);
    if (rd_cyc.size() > rdb) check("gate_start", 64'(rd_cyc[rdb] - c_en), 64'd1);
    check_stream("gate", rxb);

    // Reset mid-burst after the 7th word (values 1..16)
    enable = 1'b0;
    load(16, 1'b1, 1);
    preload();
    rxb = rx.size();
    enable = 1'b1;
    t = 0;
    while ((rx.size() - rxb) < 7 && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("mrst_seen7", 64'(rx.size() - rxb), 64'd7);
    arst_n = 1'b0;
    #1;
    check("mrst_rdreq", 64'(rdreq), 64'd0);
    check("mrst_valid", 64'(m_valid), 64'd0);
    check("mrst_data",  64'(m_data), 64'd0);
    check("mrst_sop",   64'(m_sop), 64'd0);
    check("mrst_eop",   64'(m_eop), 64'd0);
    check("mrst_busy",  64'(busy), 64'd0);
    @(posedge clk);
    #1;
    check("mrst_usedw", 64'(fifo_usedw), 64'd9);
    for (int k = 0; k < 7; k++) begin
      e = {(k == 0), 1'b0, DW'(k + 1)};
      if (rxb + k < rx.size()) check("mrst_pre", 64'(rx[rxb + k]), 64'(e));
    end
    @(negedge clk);
    arst_n = 1'b1;
    rxb = rx.size();
    expw.delete();
    for (int k = 8; k <= 16; k++) expw.push_back(DW'(k));
    run_until_idle("mrst", 1000);
    check_stream("mrst", rxb);

    // Random lengths and data under random backpressure
    for (int it = 0; it < 3; it++) begin
      enable = 1'b0;
      rmode = 0;
      n = $urandom_range(1, 50);
      load(n, 1'b0, 0);
      preload();
      rxb = rx.size();
      rmode = 2;
      enable = 1'b1;
      run_until_idle("rnd", 3000);
      check_stream("rnd", rxb);
    end

    check("end_underflow", 64'(underflow_err), 64'd0);
    check("end_skid_rd", 64'(skid_rd_err), 64'd0);
    check("end_stable", 64'(stall_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
